// File: rtl/seq_mult_n_pkg.sv
// mult_pkg: shared FSM state type and 7-segment helpers for seq_mult_n
package mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] nibble_to_seg(input logic [3:0] n);
    return SEG_LUT[n];
  endfunction
endpackage

// File: rtl/seq_mult_n_if.sv
// seq_mult_n_if: operand/control inputs and product/status/display outputs of seq_mult_n
interface seq_mult_n_if #(parameter int WIDTH = 8);
  logic ClearA_LoadB_h;
  logic Run_h;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] AVal;
  logic [WIDTH-1:0] BVal;
  logic Xval;
  logic Busy;
  logic Done;
  logic [WIDTH/2-1:0][6:0] HEX;
  modport master (output ClearA_LoadB_h, Run_h, Din, input AVal, BVal, Xval, Busy, Done, HEX);
  modport slave (input ClearA_LoadB_h, Run_h, Din, output AVal, BVal, Xval, Busy, Done, HEX);
endinterface

// File: rtl/seq_mult_n_hex_driver.sv
// hex_driver: combinational nibble to active-low 7-segment pattern
module hex_driver
  import mult_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = nibble_to_seg(nib);
endmodule

// File: rtl/seq_mult_n.sv
// seq_mult_n: signed add-shift multiplier, {A,B} = B x S; HEX readout enabled by HEX_DISPLAY_EN
module seq_mult_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic Clk,
  input  logic Reset_h,
  seq_mult_n_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] a, b, s;
  logic x, run_q, start, last;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] op, sum;
  // The final step subtracts S; negating at WIDTH+1 bits keeps -(-2^(W-1)) representable
  always_comb begin
    start = bus.Run_h & ~run_q;
    last = cnt == CW'(WIDTH - 1);
    op = last ? -{s[WIDTH-1], s} : {s[WIDTH-1], s};
    sum = {a[WIDTH-1], a} + (b[0] ? op : '0);
    state_n = state == IDLE ? ((start & ~bus.ClearA_LoadB_h) ? CALC : IDLE)
            : state == CALC ? (last ? DONE : CALC)
            : (bus.Run_h ? DONE : IDLE);
  end
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      s <= '0;
      x <= 1'b0;
      cnt <= '0;
      run_q <= 1'b0;
    end else begin
      state <= state_n;
      run_q <= bus.Run_h;
      if (state == IDLE && bus.ClearA_LoadB_h) begin
        a <= '0;
        x <= 1'b0;
        b <= bus.Din;
      end else if (state == IDLE && start) begin
        s <= bus.Din;
        a <= '0;
        x <= 1'b0;
        cnt <= '0;
      end else if (state == CALC) begin
        x <= sum[WIDTH];
        a <= sum[WIDTH:1];
        b <= {sum[0], b[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign bus.AVal = a;
  assign bus.BVal = b;
  assign bus.Xval = x;
  assign bus.Busy = state == CALC;
  assign bus.Done = state == DONE;
`ifdef HEX_DISPLAY_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {a, b};
  for (genvar i = 0; i < WIDTH / 2; i++) begin : g_hex
    hex_driver u_hex (.nib(prod[4*i+:4]), .seg(bus.HEX[i]));
  end
`else
  assign bus.HEX = {(WIDTH / 2){SEG_BLANK}};
`endif
endmodule

// File: tb/tb_seq_mult_n.sv
// tb_seq_mult_n: randomized self-checking bench for seq_mult_n against a signed-product model
module tb_seq_mult_n;
  localparam int W = 8;
  logic Clk = 1'b0;
  logic Reset_h;
  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] bm;
  seq_mult_n_if #(.WIDTH(W)) bus ();
  seq_mult_n #(.WIDTH(W)) dut (.Clk(Clk), .Reset_h(Reset_h), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction
  task automatic check_hex(input logic [2*W-1:0] p);
    for (int i = 0; i < W / 2; i++) begin
`ifdef HEX_DISPLAY_EN
      check($sformatf("hex%0d", i), bus.HEX[i], seg_of(p[4*i+:4]));
`else
      check($sformatf("hex%0d", i), bus.HEX[i], 7'h7F);
`endif
    end
  endtask
  task automatic do_load(input logic [W-1:0] v);
    @(negedge Clk);
    bus.ClearA_LoadB_h = 1'b1;
    bus.Din = v;
    @(negedge Clk);
    bus.ClearA_LoadB_h = 1'b0;
    check("load_a", bus.AVal, 0);
    check("load_b", bus.BVal, v);
    bm = v;
  endtask
  task automatic do_run(input logic [W-1:0] din, input bit poke);
    int p, busy, cyc;
    logic [2*W-1:0] exp;
    p = int'($signed(bm)) * int'($signed(din));
    exp = p[2*W-1:0];
    @(negedge Clk);
    bus.Din = din;
    bus.Run_h = 1'b1;
    busy = 0;
    cyc = 0;
    @(negedge Clk);
    while (!bus.Done && cyc < 40) begin
      if (bus.Busy) busy++;
      bus.ClearA_LoadB_h = poke && busy == 3;
      if (poke && busy == 3) bus.Din = ~din;
      @(negedge Clk);
      cyc++;
    end
    bus.ClearA_LoadB_h = 1'b0;
    check("busy_cycles", busy, W);
    check("done", bus.Done, 1);
    check("product", {bus.AVal, bus.BVal}, exp);
    check("xval", bus.Xval, exp[2*W-1]);
    check_hex(exp);
    repeat (3) @(negedge Clk);
    check("hold_done", bus.Done, 1);
    check("hold_busy", bus.Busy, 0);
    check("hold_product", {bus.AVal, bus.BVal}, exp);
    bus.Run_h = 1'b0;
    @(negedge Clk);
    check("back_idle", {bus.Busy, bus.Done}, 0);
    bm = exp[W-1:0];
  endtask
  initial begin
    Reset_h = 1'b1;
    bus.ClearA_LoadB_h = 1'b0;
    bus.Run_h = 1'b0;
    bus.Din = '0;
    bm = '0;
    repeat (3) @(negedge Clk);
    check("rst_state", {bus.AVal, bus.BVal, bus.Xval, bus.Busy, bus.Done}, 0);
    Reset_h = 1'b0;
    do_load(8'h07); do_run(8'hFE, 1'b0);
    do_run(8'h01, 1'b0);
    do_load(8'hF5); do_run(8'h06, 1'b0);
    do_load(8'hF5); do_run(8'hFA, 1'b0);
    do_load(8'h0B); do_run(8'h06, 1'b0);
    do_load(8'h80); do_run(8'h80, 1'b0);
    check("min_x_min", {bus.AVal, bus.BVal}, 16'h4000);
    do_load(8'h06); do_run(8'hD7, 1'b0);
    check("hex_case", {bus.AVal, bus.BVal}, 16'hFF0A);
    do_load(8'h5A); do_run(8'hC3, 1'b1);
    @(negedge Clk);
    bus.ClearA_LoadB_h = 1'b1;
    bus.Run_h = 1'b1;
    bus.Din = 8'h3C;
    @(negedge Clk);
    check("coinc_busy", bus.Busy, 0);
    check("coinc_load", bus.BVal, 8'h3C);
    bus.ClearA_LoadB_h = 1'b0;
    bus.Run_h = 1'b0;
    bm = 8'h3C;
    @(negedge Clk);
    bus.Din = 8'h77;
    bus.Run_h = 1'b1;
    repeat (4) @(negedge Clk);
    check("pre_rst_busy", bus.Busy, 1);
    Reset_h = 1'b1;
    bus.Run_h = 1'b0;
    @(negedge Clk);
    check("mid_rst", {bus.AVal, bus.BVal, bus.Xval, bus.Busy, bus.Done}, 0);
    Reset_h = 1'b0;
    bm = '0;
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 2) != 0) do_load(W'($urandom));
      do_run(W'($urandom), $urandom_range(0, 3) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
